// File: rtl/key_input_conditioner_if.sv
// Key bundle between the board buttons, the conditioner and whatever consumes
// the conditioned key events.
interface key_input_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] KEY;          // raw buttons, active-low
    logic [NUM_KEYS-1:0] key_down;     // debounced level, active-high
    logic [NUM_KEYS-1:0] key_press;    // one-cycle press event
    logic [NUM_KEYS-1:0] key_release;  // one-cycle release event
    logic [NUM_KEYS-1:0] key_repeat;   // one-cycle typematic event

    // Conditioner side: consumes raw pins, produces events.
    modport master (
        input  KEY,
        output key_down, key_press, key_release, key_repeat
    );

    // Consumer side: reads the conditioned events.
    modport slave (
        input  key_down, key_press, key_release, key_repeat
    );
endinterface

// File: rtl/key_input_conditioner.sv
// Pushbutton conditioner: per-key 2-flop sync, debounce, press/release pulses
// and typematic auto-repeat. Every key is an independent channel instance.

module key_input_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic key_down,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam bit RP_EN  = (REPEAT_DELAY > 0);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_DLY  = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_RATE = RP_W'(REPEAT_RATE);
    localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);

    logic            sync1, sync2;
    logic            stable;     // debounced raw level (1 = released)
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rp_cnt;

    // Edge detection compares the already-flipped stable level against the
    // registered key_down, so the pulse lands with the new key_down value.
    logic press_nxt, release_nxt, rep_fire;
    assign press_nxt   = ~stable & ~key_down;
    assign release_nxt =  stable &  key_down;
    // A release on the same edge as an expiry suppresses the repeat.
    assign rep_fire    = RP_EN && key_down && !release_nxt && (rp_cnt == RP_ONE);

    // Two-flop synchronizer, idles at released.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive differing samples, any agreement restarts.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            stable <= 1'b1;
            db_cnt <= '0;
        end else if (sync2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Registered level and press/release event outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_down    <= ~stable;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Typematic down-counter: delay after press, then fixed rate while held.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            rp_cnt     <= '0;
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= rep_fire;
            if (!RP_EN)
                rp_cnt <= '0;
            else if (press_nxt)
                rp_cnt <= RP_DLY;
            else if (!key_down || release_nxt)
                rp_cnt <= '0;
            else if (rep_fire)
                rp_cnt <= RP_RATE;
            else if (rp_cnt != '0)
                rp_cnt <= rp_cnt - RP_ONE;
        end
    end
endmodule

module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    key_input_conditioner_if.master   bus
);
    logic [NUM_KEYS-1:0] down_v, press_v, release_v, repeat_v;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_input_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .resetn      (resetn),
            .key_n       (bus.KEY[i]),
            .key_down    (down_v[i]),
            .key_press   (press_v[i]),
            .key_release (release_v[i]),
            .key_repeat  (repeat_v[i])
        );
    end

    assign bus.key_down    = down_v;
    assign bus.key_press   = press_v;
    assign bus.key_release = release_v;
    assign bus.key_repeat  = repeat_v;
endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with short debounce/repeat timing.
module tb_key_input_conditioner;
    logic clk;
    logic resetn;

    key_input_conditioner_if #(.NUM_KEYS(4)) kif();

    key_input_conditioner #(
        .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Mid-cycle event tallies per key.
    int pcnt[4] = '{default: 0};
    int rcnt[4] = '{default: 0};
    int qcnt[4] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (kif.key_press[i]   === 1'b1) pcnt[i]++;
            if (kif.key_release[i] === 1'b1) rcnt[i]++;
            if (kif.key_repeat[i]  === 1'b1) qcnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int p0, p1, p3, r0, r1, r3, q0, q2, q3;

    initial begin
        resetn  = 1'b0;
        kif.KEY = 4'b0000;

        // Reset with all keys held: outputs quiet, then a fresh press of all.
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rst_outs", 32'({kif.key_down, kif.key_press, kif.key_release, kif.key_repeat}), 0);
        end
        resetn = 1'b1;
        tick(6);
        check("rst_down_pre", 32'(kif.key_down), 32'h0);
        tick(1);
        check("rst_down", 32'(kif.key_down), 32'hf);
        check("rst_press", 32'(kif.key_press), 32'hf);
        tick(1);
        check("rst_press_1cyc", 32'(kif.key_press), 32'h0);
        kif.KEY = 4'b1111;
        tick(6);
        check("rst_rel_pre", 32'(kif.key_down), 32'hf);
        tick(1);
        check("rst_rel_down", 32'(kif.key_down), 32'h0);
        check("rst_rel", 32'(kif.key_release), 32'hf);
        tick(1);
        check("rst_rel_1cyc", 32'(kif.key_release), 32'h0);
        tick(3);

        // Clean press/release on key 0, released one cycle after a repeat.
        p0 = pcnt[0]; r0 = rcnt[0]; q0 = qcnt[0];
        kif.KEY = 4'b1110;
        tick(6);
        check("k0_down_pre", 32'(kif.key_down[0]), 0);
        tick(1);
        check("k0_down", 32'(kif.key_down), 32'h1);
        check("k0_press", 32'(kif.key_press), 32'h1);
        tick(1);
        check("k0_press_1cyc", 32'(kif.key_press[0]), 0);
        tick(12);
        kif.KEY = 4'b1111;
        tick(6);
        check("k0_rel_pre", 32'(kif.key_down[0]), 1);
        tick(1);
        check("k0_rel_down", 32'(kif.key_down[0]), 0);
        check("k0_rel", 32'(kif.key_release), 32'h1);
        tick(1);
        check("k0_rel_1cyc", 32'(kif.key_release[0]), 0);
        tick(1);
        check("k0_npress", pcnt[0] - p0, 1);
        check("k0_nrel", rcnt[0] - r0, 1);
        check("k0_nrep", qcnt[0] - q0, 4);

        // Glitches on key 1 all shorter than the debounce window.
        p1 = pcnt[1]; r1 = rcnt[1];
        kif.KEY[1] = 1'b0; tick(3);
        kif.KEY[1] = 1'b1; tick(1);
        kif.KEY[1] = 1'b0; tick(2);
        kif.KEY[1] = 1'b1; tick(1);
        kif.KEY[1] = 1'b0; tick(2);
        kif.KEY[1] = 1'b1; tick(10);
        check("k1_glitch_down", 32'(kif.key_down[1]), 0);
        check("k1_glitch_press", pcnt[1] - p1, 0);
        check("k1_glitch_rel", rcnt[1] - r1, 0);

        // Auto-repeat on key 2; release lands on an expiry cycle.
        kif.KEY[2] = 1'b0;
        tick(7);
        check("k2_press", 32'(kif.key_press), 32'h4);
        q2 = qcnt[2];
        tick(10);
        check("k2_rep10", 32'(kif.key_repeat), 32'h4);
        tick(1);
        check("k2_rep11", 32'(kif.key_repeat[2]), 0);
        tick(2);
        check("k2_rep13", 32'(kif.key_repeat[2]), 1);
        tick(3);
        check("k2_rep16", 32'(kif.key_repeat[2]), 1);
        tick(2);
        kif.KEY[2] = 1'b1;
        tick(4);
        check("k2_rep22", 32'(kif.key_repeat[2]), 1);
        tick(3);
        check("k2_rel25", 32'(kif.key_release), 32'h4);
        check("k2_norep25", 32'(kif.key_repeat[2]), 0);
        check("k2_down25", 32'(kif.key_down[2]), 0);
        tick(2);
        check("k2_nrep", qcnt[2] - q2, 5);

        // Keys 0 and 3 together; key 3 bounces once and is pressed 3 later.
        p0 = pcnt[0]; p3 = pcnt[3]; q0 = qcnt[0]; q3 = qcnt[3];
        kif.KEY = 4'b0110;
        tick(2);
        kif.KEY[3] = 1'b1;
        tick(1);
        kif.KEY[3] = 1'b0;
        tick(4);
        check("sim_press0", 32'(kif.key_press), 32'h1);
        check("sim_down_e6", 32'(kif.key_down), 32'h1);
        tick(3);
        check("sim_press3", 32'(kif.key_press), 32'h8);
        check("sim_down_e9", 32'(kif.key_down), 32'h9);
        tick(1);
        kif.KEY = 4'b1111;
        tick(6);
        check("sim_rel_pre", 32'(kif.key_down), 32'h9);
        tick(1);
        check("sim_rel", 32'(kif.key_release), 32'h9);
        check("sim_rel_down", 32'(kif.key_down), 32'h0);
        tick(2);
        check("sim_np0", pcnt[0] - p0, 1);
        check("sim_np3", pcnt[3] - p3, 1);
        check("sim_nq0", qcnt[0] - q0, 1);
        check("sim_nq3", qcnt[3] - q3, 0);

        // Reset pulse while key 1 is held: no release, fresh press afterwards.
        p1 = pcnt[1];
        kif.KEY = 4'b1101;
        tick(7);
        check("mr_press", 32'(kif.key_press), 32'h2);
        tick(2);
        r1 = rcnt[1];
        resetn = 1'b0;
        tick(1);
        check("mr_outs", 32'({kif.key_down, kif.key_press, kif.key_release, kif.key_repeat}), 0);
        resetn = 1'b1;
        tick(6);
        check("mr_down_pre", 32'(kif.key_down), 32'h0);
        tick(1);
        check("mr_repress", 32'(kif.key_press), 32'h2);
        check("mr_down", 32'(kif.key_down), 32'h2);
        tick(2);
        check("mr_nrel", rcnt[1] - r1, 0);
        check("mr_npress", pcnt[1] - p1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
